// File: rtl/count_match_capture.sv
// Compare/PWM and trigger-capture unit downstream of the 8-bit loadable counter.
// Optional macro CMP_SHADOW_EN: compare writes go through a shadow register applied at cnt_in==0.
module count_match_capture #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [W-1:0] cnt_in,
  input  logic         cmp_wr,
  input  logic [W-1:0] cmp_val,
  input  logic         arm,
  input  logic         cap_trig,
  input  logic         flag_clr,
  output logic         match,
  output logic         pwm_out,
  output logic [W-1:0] cap_val,
  output logic         cap_valid,
  output logic         overrun,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    CAPTURED = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           cmp_reg;
  logic                   eq, eq_prev;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist, trig_edge;
  logic [W-1:0]           cap_val_d;
  logic                   cap_valid_d, overrun_d;

`ifdef CMP_SHADOW_EN
  logic [W-1:0] cmp_shadow;

  // A zero-crossing transfer uses the shadow as it was before this edge's write.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cmp_shadow <= '0;
      cmp_reg    <= '0;
    end else begin
      if (cmp_wr) cmp_shadow <= cmp_val;
      if (cnt_in == '0) cmp_reg <= cmp_shadow;
    end
  end
`else
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cmp_reg <= '0;
    else if (cmp_wr) cmp_reg <= cmp_val;
  end
`endif

  assign eq = (cnt_in == cmp_reg);

  // compare stage
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      eq_prev <= 1'b0;
      match   <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      eq_prev <= eq;
      match   <= eq & ~eq_prev;
      pwm_out <= (cnt_in < cmp_reg);
    end
  end

  // trigger synchronizer and edge history
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_ff <= '0;
      hist    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], cap_trig};
      hist    <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign trig_edge = sync_ff[SYNC_STAGES-1] & ~hist;

  always_comb begin
    state_d     = state_q;
    cap_val_d   = cap_val;
    cap_valid_d = cap_valid;
    overrun_d   = overrun;
    if (flag_clr) begin
      state_d     = IDLE;
      cap_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE:     if (arm) state_d = ARMED;
        ARMED: begin
          if (trig_edge) begin
            cap_val_d   = cnt_in;
            cap_valid_d = 1'b1;
            state_d     = CAPTURED;
          end
        end
        CAPTURED: if (trig_edge) overrun_d = 1'b1;
        default:  state_d = IDLE;
      endcase
    end
  end

  // capture stage
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cap_val   <= '0;
      cap_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_val   <= cap_val_d;
      cap_valid <= cap_valid_d;
      overrun   <= overrun_d;
    end
  end

  assign state = state_q;

endmodule

// File: doc/count_match_capture.md
Name: count_match_capture

Overview:
Downstream consumer of the 8-bit loadable counter value. It compares the counter value against a programmable compare register and produces a registered match pulse and a PWM-style level. It also captures the counter value on a synchronized external trigger, using an arm/capture/clear state machine with sticky overrun detection. It sits between the counter output bus and the pin/status logic.

Parameters:
W, 8, width of cnt_in, cmp_val, cap_val
SYNC_STAGES, 2, flip-flop depth of the cap_trig synchronizer (minimum 2)

Ports:
clk  input  1  system clock, all state on rising edge
arst_n  input  1  reset, asynchronous assert, active-low; clears all state
cnt_in  input  W  counter value (upstream counter output)
cmp_wr  input  1  write strobe for compare register
cmp_val  input  W  compare value written when cmp_wr=1
arm  input  1  one-cycle request to arm capture
cap_trig  input  1  asynchronous capture trigger, rising-edge sensitive
flag_clr  input  1  clears cap_valid and overrun, returns FSM to IDLE
match  output  1  one-cycle pulse on entry to cnt_in==compare
pwm_out  output  1  registered (cnt_in < compare)
cap_val  output  W  captured counter value
cap_valid  output  1  capture holds valid data
overrun  output  1  sticky: trigger edge seen while already CAPTURED
state  output  2  FSM state: 00 IDLE, 01 ARMED, 10 CAPTURED

Behaviour:
- Reset (arst_n=0, any time, including mid-capture): cmp_reg=0, match=0, pwm_out=0, cap_val=0, cap_valid=0, overrun=0, state=IDLE, synchronizer and edge history=0, eq_prev=0.
- Compare register: cmp_wr=1 loads cmp_val at the next edge. The new value is used for compare from the following cycle.
- eq = (cnt_in == cmp_reg). match <= eq & ~eq_prev, then eq_prev <= eq.
  - Latency is 1 cycle.
  - A counter holding at the compare value gives exactly one pulse.
  - Wrap from 0xFF to 0x00 with cmp_reg=0 gives a pulse.
- pwm_out <= (cnt_in < cmp_reg), unsigned. cmp_reg=0 gives constant 0; cmp_reg=0xFF gives 1 for every cnt_in except 0xFF.
- Trigger path:
  - cap_trig passes through SYNC_STAGES flip-flops, then one history flip-flop.
  - trig_edge = sync_out & ~hist.
  - A rising edge present before clock edge k produces a capture at edge k+SYNC_STAGES, sampling the cnt_in present at that edge.
- FSM:
  - IDLE: arm=1 moves to ARMED. Trigger edges are ignored.
  - ARMED: trig_edge loads cap_val<=cnt_in, sets cap_valid<=1, moves to CAPTURED. arm has no effect.
  - CAPTURED: trig_edge sets overrun<=1; cap_val is not overwritten. arm is ignored.
  - Any state: flag_clr=1 clears cap_valid and overrun and moves to IDLE. flag_clr has priority over arm and trig_edge in the same cycle; that edge is dropped.
- cap_val holds its last value after flag_clr and is only overwritten by a new capture.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
CMP_SHADOW_EN
- Defined: cmp_wr writes a shadow register. The shadow is copied to the active cmp_reg at the first edge where cnt_in==0, giving glitch-free PWM period updates. A write and a transfer in the same cycle transfer the old shadow value, and the new value waits for the next zero.
- Undefined: no shadow register; cmp_wr updates the active compare directly, as described in Behaviour.

Test Plan:
- Reset mid-capture: arm, trigger, then assert arst_n=0 -> all outputs 0, state=00 asynchronously, before the next clk edge.
- cmp_wr with cmp_val=0x05, cnt_in stepping 0x03..0x08 -> match high for exactly 1 cycle, the cycle after cnt_in=0x05; pwm_out=1 while registered cnt_in<0x05.
- cnt_in held at 0x05 for 10 cycles with cmp=0x05 -> single match pulse. Wrap 0xFF->0x00 with cmp=0x00 -> one pulse.
- arm, then raise cap_trig with cnt_in incrementing from 0x10 -> cap_val equals cnt_in at edge k+2 (SYNC_STAGES=2), cap_valid=1, state=10; second trigger edge -> overrun=1, cap_val unchanged.
- flag_clr asserted in the same cycle as trig_edge while ARMED -> state=00, cap_valid=0, no capture; a later trigger without arm does not change cap_val.
- CMP_SHADOW_EN: write 0x80 while cnt_in=0x40, old cmp=0x20 -> pwm_out follows 0x20 until cnt_in reaches 0x00, then follows 0x80.
